// File: rtl/serial_rx4_pkg.sv
// Shared definitions for the serial_rx4 input stage: frame length,
// FSM state encoding and the data-bit placement helper.
package serial_rx4_pkg;

    // Number of data bits carried between the start and stop bits.
    localparam int FRAME_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    // Bit position that the cnt-th received data bit lands in.
    function automatic logic [1:0] bit_slot(input logic [1:0] cnt, input bit msb_first);
        return msb_first ? (2'(FRAME_BITS - 1) - cnt) : cnt;
    endfunction

endpackage

// File: rtl/serial_rx4_if.sv
// Serial line in, held parallel word and status pulses out.
interface serial_rx4_if;
    import serial_rx4_pkg::*;

    logic                  sin;
    logic                  sin_en;
    logic [FRAME_BITS-1:0] dout;
    logic                  valid;
    logic                  err;
    logic                  busy;

    // Line driver / consumer side.
    modport master (output sin, sin_en, input dout, valid, err, busy);
    // Receiver side.
    modport slave  (input sin, sin_en, output dout, valid, err, busy);

endinterface

// File: rtl/serial_rx4_shreg4.sv
// 4-bit data register with per-bit write enable; all enabled bits load d.
module shreg4
    import serial_rx4_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] we,
    input  logic                  d,
    output logic [FRAME_BITS-1:0] q
);

    // Load the serial bit into whichever positions are enabled this edge.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this is data-path storage, but it is reset anyway so that the
        // whole receiver comes out of reset in a known, all-zero condition.
        if (!rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < FRAME_BITS; i++) begin
                if (we[i]) q[i] <= d;
            end
        end
    end

endmodule

// File: rtl/serial_rx4.sv
// Framed serial receiver: start bit, 4 data bits, stop bit, sampled on
// sin_en. Holds the last good word on dout; framing errors pulse err.
module serial_rx4
    import serial_rx4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    serial_rx4_if.slave bus
);

    state_t                state;
    logic [1:0]            cnt;
    logic [FRAME_BITS-1:0] word;
    logic [FRAME_BITS-1:0] we;
    logic [FRAME_BITS-1:0] dout_q;
    logic                  valid_q;
    logic                  err_q;

    // Enable exactly one data-bit slot on each strobed DATA edge.
    always_comb begin
        // NOTE: default first so every path assigns we and no latch is inferred.
        we = '0;
        if (state == DATA && bus.sin_en) we[bit_slot(cnt, MSB_FIRST)] = 1'b1;
    end

    shreg4 u_shreg (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .d   (bus.sin),
        .q   (word)
    );

    // Frame FSM, bit counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bus.sin_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.sin) begin
                            state <= DATA;
                            cnt   <= 2'd0;
                        end
                    end
                    DATA: begin
                        if (cnt == 2'(FRAME_BITS - 1)) state <= STOP;
                        else                           cnt   <= cnt + 2'd1;
                    end
                    STOP: begin
                        if (bus.sin) begin
                            dout_q  <= word;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_serial_rx4.sv
// Self-checking bench for serial_rx4: one LSB-first and one MSB-first
// instance see identical line activity and are checked side by side.
module tb_serial_rx4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Model of the held words for the two bit orders.
    logic [3:0] m0;
    logic [3:0] m1;

    serial_rx4_if if0 ();
    serial_rx4_if if1 ();

    serial_rx4 #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    serial_rx4 #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1);
    end

    typedef struct {
        logic [5:0] seq;    // line bits, seq[5] sent first
        logic [3:0] exp0;   // dout after frame, LSB-first instance
        logic [3:0] exp1;   // dout after frame, MSB-first instance
        logic       good;   // stop bit correct
    } frame_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] d0, input logic [3:0] d1,
                              input logic v, input logic e, input logic b);
        check({name, " dout0"},  32'(if0.dout),  32'(d0));
        check({name, " dout1"},  32'(if1.dout),  32'(d1));
        check({name, " valid0"}, 32'(if0.valid), 32'(v));
        check({name, " valid1"}, 32'(if1.valid), 32'(v));
        check({name, " err0"},   32'(if0.err),   32'(e));
        check({name, " err1"},   32'(if1.err),   32'(e));
        check({name, " busy0"},  32'(if0.busy),  32'(b));
        check({name, " busy1"},  32'(if1.busy),  32'(b));
    endtask

    // Drive one edge's inputs and move to the following falling edge.
    task automatic step(input logic s, input logic en);
        if0.sin = s;  if0.sin_en = en;
        if1.sin = s;  if1.sin_en = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Up to max_gap unstrobed cycles of random line noise, then one strobed bit.
    task automatic strobed(input logic b, input int max_gap, input logic busy_now);
        int gap;
        gap = $urandom_range(0, max_gap);
        for (int i = 0; i < gap; i++) begin
            step(1'($urandom), 1'b0);
            check_outs("gap", m0, m1, 1'b0, 1'b0, busy_now);
        end
        step(b, 1'b1);
    endtask

    // Full frame; a[i] is the i-th data bit on the line.
    task automatic send_frame(input logic [3:0] a, input logic stop, input int max_gap);
        strobed(1'b0, max_gap, 1'b0);
        check_outs("start", m0, m1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            strobed(a[i], max_gap, 1'b1);
            check_outs("data", m0, m1, 1'b0, 1'b0, 1'b1);
        end
        strobed(stop, max_gap, 1'b1);
        if (stop) begin
            m0 = a;
            m1 = {a[0], a[1], a[2], a[3]};
        end
        check_outs("stop", m0, m1, stop, ~stop, 1'b0);
    endtask

    initial begin
        frame_vec_t vecs[4];
        logic [5:0] s6;
        logic [3:0] a;
        logic       stop;

        n_checks = 0;
        n_fail   = 0;
        m0 = 4'h0;
        m1 = 4'h0;

        vecs[0] = '{seq: 6'b010111, exp0: 4'hD, exp1: 4'hB, good: 1'b1};
        vecs[1] = '{seq: 6'b000000, exp0: 4'hD, exp1: 4'hB, good: 1'b0};
        vecs[2] = '{seq: 6'b001011, exp0: 4'hA, exp1: 4'h5, good: 1'b1};
        vecs[3] = '{seq: 6'b010101, exp0: 4'h5, exp1: 4'hA, good: 1'b1};

        rst = 1'b0;
        if0.sin = 1'b1; if0.sin_en = 1'b0;
        if1.sin = 1'b1; if1.sin_en = 1'b0;
        #12;
        check_outs("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Directed frames, sin_en tied high, back to back.
        for (int f = 0; f < 4; f++) begin
            s6 = vecs[f].seq;
            for (int k = 0; k < 6; k++) begin
                step(s6[5 - k], 1'b1);
                if (k == 5) begin
                    m0 = vecs[f].exp0;
                    m1 = vecs[f].exp1;
                end
                check_outs($sformatf("vec%0d edge%0d", f, k), m0, m1,
                           (k == 5) && vecs[f].good, (k == 5) && !vecs[f].good, k < 5);
            end
            // After the error frame the receiver must sit in IDLE on idle 1s.
            if (!vecs[f].good) begin
                for (int k = 0; k < 3; k++) begin
                    step(1'b1, 1'b1);
                    check_outs("idle after err", m0, m1, 1'b0, 1'b0, 1'b0);
                end
            end
        end

        // Strobe every third cycle, line inverted on unstrobed cycles; word 4'h6.
        s6 = 6'b001101;
        for (int k = 0; k < 6; k++) begin
            step(~s6[5 - k], 1'b0);
            step(~s6[5 - k], 1'b0);
            step(s6[5 - k], 1'b1);
        end
        m0 = 4'h6;
        m1 = 4'h6;
        check_outs("strobe3 after 18", m0, m1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_outs("strobe3 valid drop", m0, m1, 1'b0, 1'b0, 1'b0);

        // Reset after the second data bit of a frame.
        strobed(1'b0, 0, 1'b0);
        strobed(1'b1, 0, 1'b1);
        strobed(1'b0, 0, 1'b1);
        check_outs("pre mid reset", m0, m1, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        m0 = 4'h0;
        m1 = 4'h0;
        check_outs("mid reset", m0, m1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(4'b0011, 1'b1, 0);
        check("after reset frame dout0", 32'(if0.dout), 32'h3);
        check("after reset frame dout1", 32'(if1.dout), 32'hC);

        // Randomized frames with noisy gaps and idle bits.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                strobed(1'b1, 2, 1'b0);
                check_outs("rand idle", m0, m1, 1'b0, 1'b0, 1'b0);
            end
            a    = 4'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(a, stop, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_rx4.md
# serial_rx4

Serial-to-parallel input stage that sits directly upstream of the team's 4-bit D flip-flop register. It receives a framed serial bit stream (start bit, 4 data bits, stop bit) sampled on an external strobe, assembles the 4-bit word, and presents it on a held output. The downstream 4-bit register samples that output on every clock. Framing errors are flagged and never corrupt the held word.

## Interface
- MSB_FIRST, default 0: bit order of the data field. 0 = LSB first, 1 = MSB first.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data line; idle level 1.
- sin_en  input  1  sample strobe; `sin` is examined only on edges where `sin_en` = 1.
- dout  output  4  last correctly framed word, held between frames; drives the 4-bit register's `d`.
- valid  output  1  one-cycle pulse when `dout` has just been updated.
- err  output  1  one-cycle pulse on a stop-bit error.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Reset (`rst` = 0, asynchronous): state = IDLE, bit counter = 0, shift register = 0, `dout` = 4'h0, `valid` = 0, `err` = 0, `busy` = 0.
- States:
  - IDLE
  - DATA (2-bit counter `cnt`)
  - STOP
- Edges with `sin_en` = 0 change no state, counter or shift register. `valid` and `err` still return to 0 on that edge.
- IDLE:
  - `sin_en` = 1 and `sin` = 0 → DATA, `cnt` = 0.
  - `sin` = 1 → stay in IDLE.
- DATA, on `sin_en` = 1:
  - MSB_FIRST = 0: store `sin` into bit `cnt`.
  - MSB_FIRST = 1: store `sin` into bit 3 − `cnt`.
  - `cnt` < 3: `cnt` increments.
  - `cnt` = 3: go to STOP.
- STOP, on `sin_en` = 1:
  - `sin` = 1: `dout` ← shift register, `valid` = 1 for one cycle, go to IDLE.
  - `sin` = 0: `err` = 1 for one cycle, `dout` unchanged, go to IDLE. The 0 is not reinterpreted as a new start bit.
- Back-to-back frames: a start bit may be sampled on the first `sin_en` edge after STOP completes. No gap cycle is required.
- The shift register is not cleared between frames. Every data bit is overwritten before use.
- `valid` and `err` are never high in the same cycle.

## Timing
- `busy` is decoded combinationally from the state register. It goes high the cycle after the start-bit edge and low the cycle after the stop-bit edge.
- `dout`, `valid` and `err` are registered.
- Latency: `dout` and `valid` change on the same edge that samples the stop bit. The downstream register holds the word one edge later.
- With `sin_en` tied high, a full frame takes 6 edges: start, 4 data, stop.
- With `sin_en` = 1 every N cycles, a frame takes 6·N cycles.
- Reset mid-frame: the partial word is discarded and `dout` returns to 0 immediately. No `valid` or `err` pulse is produced.
- Reset deassertion is synchronised externally. On the first active edge after release the block is in IDLE.

## Structure
- State encoding (IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2) and the frame length constant (4 data bits) go in the shared package/header used by the FPGA exercise blocks.
- One sub-module is natural: `shreg4`, a 4-bit register with per-bit write enable.
  - `serial_rx4` holds the FSM, `cnt` and the output registers.
  - `shreg4` holds the data bits.

## Test plan
- Reset, then MSB_FIRST = 0 and `sin_en` tied high, send 0,1,0,1,1,1 → `dout` = 4'hD with a single `valid` pulse on the stop edge; `busy` high for exactly 5 cycles; `err` never high.
- MSB_FIRST = 1, same bit sequence → `dout` = 4'hB.
- Frame 0,0,0,0,0,0 (stop bit 0) following a good 4'hD frame → `err` pulses once, `dout` stays 4'hD, state returns to IDLE and ignores further 1s.
- `sin_en` = 1 every 3rd cycle with `sin` toggling on the off-cycles, frame carrying 4'h6 → only strobed samples are used, `dout` = 4'h6 after 18 cycles.
- Two back-to-back frames carrying 4'hA then 4'h5 with no idle bit → two `valid` pulses 6 edges apart; `dout` reads 4'hA, then 4'h5.
- Assert `rst` after the second data bit of a frame → `dout` = 0 and `busy` = 0 immediately; after release, a clean 4'h3 frame yields `dout` = 4'h3.
